// File: rtl/dff_pipe_reg.sv
// -----------------------------------------------------------------------------
// dff_pipe_reg
//
// Elastic pipeline register: WIDTH-bit words travel through STAGES flip-flop
// stages with a valid/ready handshake on both sides. Empty stages always
// accept, so bubbles collapse even while the output is stalled. Also provides
// the classic flip-flop controls: asynchronous clear, synchronous set that
// preloads every stage, and complementary q/notq outputs.
//
// Parameters
//   WIDTH      data width in bits (>= 1)
//   STAGES     number of register stages (>= 1)
//   SET_VALUE  word loaded into every stage by set
//   CW         width of count (derived)
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-high clear (highest priority)
//   set        synchronous preload of every stage, active-high
//   in_valid   producer presents in_data
//   in_data    input word
//   in_ready   block accepts in_data this cycle
//   out_valid  q holds a valid word
//   out_ready  consumer takes q this cycle
//   q          output word (last stage data)
//   notq       bitwise complement of q
//   count      number of valid stages (registered occupancy)
// -----------------------------------------------------------------------------
module dff_pipe_reg #(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       STAGES    = 4,
    parameter logic [WIDTH-1:0]  SET_VALUE = {WIDTH{1'b1}},
    localparam int unsigned      CW        = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             set,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] notq,
    output logic [CW-1:0]    count
);

    // Per-stage state; index 0 is the input side, STAGES-1 the output side.
    logic [STAGES-1:0] v_q, v_d;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [CW-1:0]     count_q, count_d;

    // Advance enables and the word/valid offered to each stage from upstream.
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] up_v;
    logic [WIDTH-1:0]  up_d [STAGES];

    // Ripple the enable from the output back to the input. A stage may
    // advance if it is empty or the stage after it advances; this is a purely
    // combinational chain from out_ready to in_ready.
    always_comb begin
        logic acc;
        en  = '0;
        acc = out_ready;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            acc   = !v_q[i] || acc;
            en[i] = acc;
        end
    end

    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int i = 1; i < int'(STAGES); i++) begin
            up_v[i] = v_q[i-1];
            up_d[i] = d_q[i-1];
        end
    end

    // Next-state: set preloads everything; otherwise each enabled stage takes
    // the upstream valid, and the upstream word only when it is valid, so an
    // empty slot never overwrites data with a stale word.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (set) begin
            v_d = '1;
            for (int i = 0; i < int'(STAGES); i++) begin
                d_d[i] = SET_VALUE;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                if (en[i]) begin
                    v_d[i] = up_v[i];
                    if (up_v[i]) begin
                        d_d[i] = up_d[i];
                    end
                end
            end
        end
    end

    // Occupancy is the population count of the next valid vector.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            count_d = count_d + CW'(v_d[i]);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int i = 0; i < int'(STAGES); i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    // No input is taken during a set cycle; the preload owns every stage.
    assign in_ready  = en[0] && !set;
    assign out_valid = v_q[STAGES-1];
    assign q         = d_q[STAGES-1];
    assign notq      = ~d_q[STAGES-1];
    assign count     = count_q;

endmodule

// File: tb/tb_dff_pipe_reg.sv
module tb_dff_pipe_reg;

    localparam int unsigned      WIDTH   = 8;
    localparam int unsigned      STAGES  = 4;
    localparam int unsigned      CW      = $clog2(STAGES + 1);
    localparam logic [WIDTH-1:0] SET_VAL = 8'hFF;

    logic             clk;
    logic             clr;
    logic             set;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] notq;
    logic [CW-1:0]    count;

    int checks = 0;
    int fails  = 0;

    // Words accepted by the pipe and not yet delivered, oldest first.
    logic [WIDTH-1:0] exp_q [$];

    dff_pipe_reg #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .SET_VALUE (SET_VAL)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .set       (set),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .notq      (notq),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs 1 time unit after the edge; returns at edge+2.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                        input logic st);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        set       = st;
        #1;
    endtask

    // Record what the coming edge will load into the pipe.
    task automatic settle();
        #2;
        if (set) begin
            exp_q.delete();
            repeat (STAGES) exp_q.push_back(SET_VAL);
        end else if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
        end
    endtask

    task automatic cyc(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                       input logic st);
        step(iv, id, ordy, st);
        settle();
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while ((exp_q.size() != 0 || count != 0) && c < maxc) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            c++;
        end
        check("drain_sb_empty", exp_q.size(), 0);
        check("drain_count", 32'(count), 0);
    endtask

    // Monitor: occupancy/in_ready against the queue after each edge, and
    // output words against the queue on every output transfer.
    initial begin
        logic [WIDTH-1:0] nq;
        logic             rdy_exp;
        logic [WIDTH-1:0] w;
        forever begin
            @(posedge clk);
            #2;
            nq      = ~q;
            rdy_exp = ((exp_q.size() < int'(STAGES)) || out_ready) && !set;
            check("mon_count", 32'(count), exp_q.size());
            check("mon_notq", 32'(notq), 32'(nq));
            check("mon_in_ready", 32'(in_ready), 32'(rdy_exp));
            @(negedge clk);
            if (out_valid && out_ready && !set) begin
                check("mon_pop_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("mon_data", 32'(q), 32'(w));
                end
            end
        end
    end

    initial begin
        int ex_cnt;
        logic iv, ordy, st;

        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        set       = 1'b0;
        clr       = 1'b0;

        // Reset values while clr is held.
        #1 clr = 1'b1;
        #2;
        check("reset_q", 32'(q), 0);
        check("reset_notq", 32'(notq), 32'hFF);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_count", 32'(count), 0);
        @(posedge clk);
        #3 clr = 1'b0;
        #1 check("reset_in_ready", 32'(in_ready), 1);

        // Latency and throughput: words 1..8 back to back, out_ready held.
        for (int k = 0; k <= 12; k++) begin
            step(k < 8, WIDTH'(k + 1), 1'b1, 1'b0);
            ex_cnt = ((k < 8) ? k : 8) - ((k > 4) ? k - 4 : 0);
            check("lat_out_valid", 32'(out_valid), 32'(k >= 4 && k <= 11));
            if (k >= 4 && k <= 11) check("lat_q", 32'(q), 32'(k - 3));
            check("lat_count", 32'(count), 32'(ex_cnt));
            settle();
        end

        // Backpressure: four fit, the fifth waits until out_ready rises.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, WIDTH'(8'hB0 + i), 1'b0, 1'b0);
            check("bp_in_ready", 32'(in_ready), 1);
            settle();
        end
        step(1'b1, 8'hB4, 1'b0, 1'b0);
        check("bp_full_in_ready", 32'(in_ready), 0);
        check("bp_full_count", 32'(count), 4);
        settle();
        step(1'b1, 8'hB4, 1'b1, 1'b0);
        check("bp_pop_in_ready", 32'(in_ready), 1);
        settle();
        drain(20);

        // Bubble collapse with the output stalled.
        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("bub_count", 32'(count), 2);
        check("bub_in_ready", 32'(in_ready), 1);
        check("bub_out_valid", 32'(out_valid), 1);
        check("bub_q", 32'(q), 32'hA1);
        settle();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        // A2 was already in the next-to-last stage, so it is at the output now.
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("bub_next_valid", 32'(out_valid), 1);
        check("bub_next_q", 32'(q), 32'hA2);
        check("bub_next_count", 32'(count), 1);
        settle();
        drain(20);

        // Set with a partly filled pipe, input offered and output being taken.
        cyc(1'b1, 8'hC1, 1'b0, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b1);
        check("set_in_ready", 32'(in_ready), 0);
        settle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("set_count", 32'(count), 4);
        check("set_q", 32'(q), 32'hFF);
        check("set_notq", 32'(notq), 32'h00);
        check("set_out_valid", 32'(out_valid), 1);
        settle();
        drain(20);

        // Asynchronous clear between edges with the pipe full.
        for (int i = 0; i < 4; i++) cyc(1'b1, WIDTH'(8'hD0 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        clr = 1'b1;
        exp_q.delete();
        #1;
        check("clr_q", 32'(q), 0);
        check("clr_notq", 32'(notq), 32'hFF);
        check("clr_out_valid", 32'(out_valid), 0);
        check("clr_count", 32'(count), 0);
        @(posedge clk);
        #3 clr = 1'b0;
        #1 check("clr_release_in_ready", 32'(in_ready), 1);
        cyc(1'b1, 8'hE1, 1'b1, 1'b0);
        drain(20);

        // Random traffic with alternating output-pressure phases.
        for (int n = 0; n < 10000; n++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ((n % 2000) < 1000) ? ($urandom_range(0, 3) != 0)
                                       : ($urandom_range(0, 3) == 0);
            st   = ($urandom_range(0, 499) == 0);
            cyc(iv, WIDTH'($urandom), ordy, st);
        end
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
